// File: rtl/display_scan_mux.sv
// Scan controller for a multiplexed seven-segment display: picks one nibble per slot,
// drives active-low anodes with dead-time, latches the value per frame, blanks leading zeros.
module display_scan_mux #(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [4*N_DIGITS-1:0]       value,
  input  logic [N_DIGITS-1:0]         dp_in,
  input  logic                        blank_lz,
  output logic [3:0]                  data_out,
  output logic                        dp_out,
  output logic [N_DIGITS-1:0]         an,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx,
  output logic                        frame_tick
);

  localparam int DW = $clog2(N_DIGITS);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [DW-1:0] DIG_LAST  = DW'(N_DIGITS - 1);

  logic [CW-1:0]         cnt, cnt_n;
  logic [DW-1:0]         digit, digit_n;
  logic [4*N_DIGITS-1:0] sh_val, sh_val_n;
  logic [N_DIGITS-1:0]   sh_dp, sh_dp_n;
  logic                  tick_n;
  logic [N_DIGITS-1:0]   lz;
  logic                  zero_run;
  logic                  lit;
  logic [N_DIGITS-1:0]   an_n;

  always_comb begin
    cnt_n    = cnt;
    digit_n  = digit;
    sh_val_n = sh_val;
    sh_dp_n  = sh_dp;
    tick_n   = 1'b0;
    if (!en) begin
      cnt_n    = '0;
      digit_n  = '0;
      sh_val_n = value;
      sh_dp_n  = dp_in;
    end else if (cnt == CNT_LAST) begin
      cnt_n = '0;
      if (digit == DIG_LAST) begin
        digit_n  = '0;
        sh_val_n = value;
        sh_dp_n  = dp_in;
        tick_n   = 1'b1;
      end else begin
        digit_n = digit + 1'b1;
      end
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end

  // lz[i] is set when nibbles i..N_DIGITS-1 of the next shadow are all zero
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (sh_val_n[4*i +: 4] == 4'h0);
      lz[i]    = zero_run;
    end
  end

  always_comb begin
    lit  = en && (cnt_n >= BLANK_END) && !(blank_lz && (digit_n != '0) && lz[digit_n]);
    an_n = '1;
    if (lit) an_n[digit_n] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      digit      <= '0;
      sh_val     <= '0;
      sh_dp      <= '0;
      data_out   <= 4'h0;
      dp_out     <= 1'b0;
      an         <= '1;
      digit_idx  <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      digit      <= digit_n;
      sh_val     <= sh_val_n;
      sh_dp      <= sh_dp_n;
      data_out   <= sh_val_n[4*digit_n +: 4];
      dp_out     <= lit & sh_dp_n[digit_n];
      an         <= an_n;
      digit_idx  <= digit_n;
      frame_tick <= tick_n;
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: position-since-restart reference model plus directed checks.
module tb_display_scan_mux;
  localparam int N = 4, SD = 8, BC = 2, FR = N * SD;

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, blank_lz = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  data_out;
  logic        dp_out;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  display_scan_mux #(.N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp_in(dp_in), .blank_lz(blank_lz),
    .data_out(data_out), .dp_out(dp_out), .an(an), .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0;
  // Model: pos = enabled edges since last restart, modulo one frame
  int          pos = 0, slot = 0, c = 0;
  logic [15:0] m_val = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  logic        m_tick = 1'b0, lit = 1'b0;
  logic [3:0]  an_e = 4'hF;
  logic [11:0] exp_v = {4'h0, 1'b0, 4'hF, 2'd0, 1'b0};

  function automatic logic [11:0] obs();
    return {data_out, dp_out, an, digit_idx, frame_tick};
  endfunction

  task automatic model_reset();
    pos = 0; slot = 0; c = 0; m_val = 16'h0; m_dp = 4'h0; m_tick = 1'b0;
    exp_v = {4'h0, 1'b0, 4'hF, 2'd0, 1'b0};
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!en) begin
      pos = 0; m_val = value; m_dp = dp_in; m_tick = 1'b0;
    end else begin
      pos = (pos + 1) % FR;
      m_tick = (pos == 0);
      if (m_tick) begin m_val = value; m_dp = dp_in; end
    end
    slot = (pos / SD) % N;
    c    = pos % SD;
    lit  = en && (c >= BC) && !(blank_lz && slot > 0 && (m_val >> (4 * slot)) == 16'h0);
    an_e = 4'hF;
    if (lit) an_e[slot] = 1'b0;
    exp_v = {m_val[4*slot +: 4], lit & m_dp[slot], an_e, 2'(slot), m_tick};
    @(negedge clk);
  endtask

  task automatic test_reset_initial();
    #12;
    checks++;
    if (obs() !== {4'h0, 1'b0, 4'hF, 2'd0, 1'b0})
      $display("FAIL reset_initial got=%h exp=%h", obs(), {4'h0, 1'b0, 4'hF, 2'd0, 1'b0});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    int ticks = 0;
    en = 1'b0; value = 16'h1234; dp_in = 4'b0100; blank_lz = 1'b0;
    cycle();
    checks++;
    if (obs() !== exp_v) $display("FAIL basic_idle got=%h exp=%h", obs(), exp_v); else passed++;
    en = 1'b1;
    for (int k = 0; k < 70; k++) begin
      cycle();
      checks++;
      if (obs() !== exp_v) $display("FAIL basic pos=%0d got=%h exp=%h", pos, obs(), exp_v); else passed++;
      if (frame_tick) ticks++;
      if (k < 32 && pos == 1) begin
        checks++;
        if (an !== 4'b1111) $display("FAIL basic_dead an=%b exp=1111", an); else passed++;
      end
      if (k < 32 && pos == 3) begin
        checks++;
        if ({data_out, an} !== {4'h4, 4'b1110}) $display("FAIL basic_slot0 got=%h/%b exp=4/1110", data_out, an); else passed++;
      end
      if (k < 32 && pos == 20) begin
        checks++;
        if ({data_out, an, dp_out} !== {4'h2, 4'b1011, 1'b1}) $display("FAIL basic_slot2 got=%h/%b/%b exp=2/1011/1", data_out, an, dp_out); else passed++;
      end
    end
    checks++;
    if (ticks != 2) $display("FAIL basic_ticks got=%0d exp=2", ticks); else passed++;
  endtask

  task automatic test_tear();
    bit seen = 0;
    for (int k = 0; k < 40 && pos != 10; k++) begin
      cycle();
      checks++;
      if (obs() !== exp_v) $display("FAIL tear_pre pos=%0d got=%h exp=%h", pos, obs(), exp_v); else passed++;
    end
    value = 16'hABCD;
    for (int k = 0; k < 60; k++) begin
      cycle();
      checks++;
      if (obs() !== exp_v) $display("FAIL tear pos=%0d got=%h exp=%h", pos, obs(), exp_v); else passed++;
      if (m_tick) seen = 1;
      if (!seen && pos == 12) begin
        checks++;
        if (data_out !== 4'h3) $display("FAIL tear_old1 got=%h exp=3", data_out); else passed++;
      end
      if (!seen && pos == 28) begin
        checks++;
        if (data_out !== 4'h1) $display("FAIL tear_old3 got=%h exp=1", data_out); else passed++;
      end
      if (seen && pos == 4) begin
        checks++;
        if (data_out !== 4'hD) $display("FAIL tear_new0 got=%h exp=d", data_out); else passed++;
      end
      if (seen && pos == 28) begin
        checks++;
        if (data_out !== 4'hA) $display("FAIL tear_new3 got=%h exp=a", data_out); else passed++;
      end
    end
  endtask

  task automatic test_lz();
    int seen = 0, lit_hi = 0;
    value = 16'h0050; blank_lz = 1'b1; dp_in = 4'h0;
    for (int k = 0; k < 150; k++) begin
      if (k == 70) begin value = 16'h0000; seen = 0; end
      if (k == 120) blank_lz = 1'b0;
      cycle();
      checks++;
      if (obs() !== exp_v) $display("FAIL lz pos=%0d got=%h exp=%h", pos, obs(), exp_v); else passed++;
      if (m_tick) seen++;
      if (k < 70 && seen >= 1 && slot >= 2 && an !== 4'b1111) lit_hi++;
      if (k < 70 && seen >= 1 && pos == 12) begin
        checks++;
        if ({data_out, an} !== {4'h5, 4'b1101}) $display("FAIL lz_slot1 got=%h/%b exp=5/1101", data_out, an); else passed++;
      end
      if (k < 70 && seen >= 1 && pos == 4) begin
        checks++;
        if ({data_out, an} !== {4'h0, 4'b1110}) $display("FAIL lz_slot0 got=%h/%b exp=0/1110", data_out, an); else passed++;
      end
      if (k >= 70 && k < 120 && seen >= 1 && (pos == 4 || pos == 12)) begin
        checks++;
        if (an !== (pos == 4 ? 4'b1110 : 4'b1111)) $display("FAIL lz_zero pos=%0d an=%b", pos, an); else passed++;
      end
      if (k >= 120 && pos == 28) begin
        checks++;
        if (an !== 4'b0111) $display("FAIL lz_off an=%b exp=0111", an); else passed++;
      end
    end
    checks++;
    if (lit_hi != 0) $display("FAIL lz_hi_lit got=%0d exp=0", lit_hi); else passed++;
    blank_lz = 1'b0;
  endtask

  task automatic test_enable_drop();
    value = 16'h1234; dp_in = 4'b0100;
    for (int k = 0; k < 40 && pos != 20; k++) begin
      cycle();
      checks++;
      if (obs() !== exp_v) $display("FAIL endrop_pre pos=%0d got=%h exp=%h", pos, obs(), exp_v); else passed++;
    end
    en = 1'b0;
    cycle();
    checks++;
    if ({an, digit_idx, dp_out, frame_tick} !== {4'b1111, 2'd0, 1'b0, 1'b0})
      $display("FAIL endrop_off an=%b idx=%0d dp=%b tick=%b", an, digit_idx, dp_out, frame_tick);
    else passed++;
    value = 16'h00F7;
    cycle();
    checks++;
    if (data_out !== 4'h7) $display("FAIL endrop_track got=%h exp=7", data_out); else passed++;
    en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      checks++;
      if (obs() !== exp_v) $display("FAIL endrop pos=%0d got=%h exp=%h", pos, obs(), exp_v); else passed++;
      if (k == 0) begin
        checks++;
        if ({an, frame_tick, data_out} !== {4'b1111, 1'b0, 4'h7}) $display("FAIL endrop_restart an=%b tick=%b d=%h", an, frame_tick, data_out); else passed++;
      end
      if (k == 1) begin
        checks++;
        if ({an, data_out} !== {4'b1110, 4'h7}) $display("FAIL endrop_lit an=%b d=%h exp=1110/7", an, data_out); else passed++;
      end
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 40 && pos != 31; k++) begin
      cycle();
      checks++;
      if (obs() !== exp_v) $display("FAIL wrap_pre pos=%0d got=%h exp=%h", pos, obs(), exp_v); else passed++;
    end
    value = 16'h5A3C; dp_in = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++;
      if (obs() !== exp_v) $display("FAIL wrap pos=%0d got=%h exp=%h", pos, obs(), exp_v); else passed++;
      checks++;
      case (k)
        0: if ({frame_tick, an, data_out} !== {1'b1, 4'b1111, 4'hC}) $display("FAIL wrap_edge tick=%b an=%b d=%h", frame_tick, an, data_out); else passed++;
        1: if ({frame_tick, an} !== {1'b0, 4'b1111}) $display("FAIL wrap_dead tick=%b an=%b", frame_tick, an); else passed++;
        default: if ({frame_tick, an, dp_out} !== {1'b0, 4'b1110, 1'b1}) $display("FAIL wrap_lit tick=%b an=%b dp=%b", frame_tick, an, dp_out); else passed++;
      endcase
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 13; k++) cycle();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({an, data_out, digit_idx, frame_tick, dp_out} !== {4'b1111, 4'h0, 2'd0, 1'b0, 1'b0})
      $display("FAIL reset_mid an=%b d=%h idx=%0d tick=%b dp=%b", an, data_out, digit_idx, frame_tick, dp_out);
    else passed++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cycle();
      checks++;
      if (obs() !== exp_v) $display("FAIL reset_after pos=%0d got=%h exp=%h", pos, obs(), exp_v); else passed++;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) value = 16'($urandom);
      if ($urandom_range(0, 3) == 0) value = {12'h0, 4'($urandom)};
      if ($urandom_range(0, 7) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom);
      en = ($urandom_range(0, 59) != 0);
      cycle();
      checks++;
      if (obs() !== exp_v) $display("FAIL random k=%0d pos=%0d got=%h exp=%h", k, pos, obs(), exp_v); else passed++;
    end
  endtask

  initial begin
    test_reset_initial();
    test_basic();
    test_tear();
    test_lz();
    test_enable_drop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
